ex_stage: RTL and testbench
===========================

EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 The block SHALL use reset rst, synchronous, active-low; clock clk.
REQ-002 The block SHALL have these ports:
 clk  in  1  clock
 rst  in  1  synchronous active-low reset
 i_valid  in  1  instruction present in EX this cycle
 i_rs_reg  in  32  rs register value from ID/EX latch
 i_rt_reg  in  32  rt register value from ID/EX latch
 i_sig_extended  in  32  sign-extended immediate; [10:6] = shamt
 i_rt_addr  in  5  rt address
 i_rd_addr  in  5  rd address
 i_ALUop  in  4  operation code (REQ-006)
 i_ALUsrc  in  1  1 = operand B is i_sig_extended
 i_shmat  in  1  1 = shift amount from shamt, 0 = from operand A[4:0]
 i_RegDst  in  1  1 = destination rd, 0 = rt
 i_RegWrite  in  1  instruction writes a GPR
 i_fwd_a  in  2  operand A source: 00 register, 01 EX/MEM, 10 MEM/WB, 11 register
 i_fwd_b  in  2  operand B source, same encoding
 i_exmem_result  in  32  forwarded EX/MEM value
 i_memwb_result  in  32  forwarded MEM/WB value
 o_result  out  32  ALU / HI / LO result
 o_store_data  out  32  forwarded operand B before the ALUsrc mux
 o_write_addr  out  5  destination register address
 o_RegWrite  out  1  qualified register write
 o_stall  out  1  hold ID/EX latch and upstream stages this cycle
 o_mul_busy  out  1  multiplier iterating

Function
REQ-003 Operand A SHALL be the i_fwd_a-selected value; forwarded B SHALL be the i_fwd_b-selected value.
REQ-004 The ALU B input SHALL be i_sig_extended when i_ALUsrc=1, else forwarded B. o_store_data SHALL always be forwarded B.
REQ-005 o_write_addr SHALL be i_rd_addr when i_RegDst=1, else i_rt_addr.
REQ-006 i_ALUop SHALL decode as: 0 ADDU, 1 SUBU, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT (signed), 7 SLTU, 8 SLL, 9 SRL, A SRA, B LUI (B<<16), C MULT, D MULTU, E MFHI, F MFLO.
REQ-007 Add and subtract SHALL wrap modulo 2^32 with no overflow trap. SLT/SLTU SHALL return 32'd1 or 32'd0.
REQ-008 Shifts SHALL shift ALU B by 5-bit amount (shamt if i_shmat=1, else A[4:0]). SRA SHALL replicate bit 31.
REQ-009 o_result SHALL be combinational. For MULT/MULTU it SHALL be 0. For MFHI/MFLO it SHALL be the HI/LO register value.
REQ-010 The multiplier SHALL have states IDLE and BUSY; o_mul_busy = (state==BUSY).
REQ-011 IDLE->BUSY SHALL occur at the edge where i_valid=1, ALUop in {C,D} and o_stall=0 (edge E0).
 At E0 the unit SHALL capture |A|, |B| (signed for C, raw for D) and a negate flag (signs differ, C only), and SHALL clear the 64-bit accumulator and the 5-bit counter.
REQ-012 In BUSY, each edge SHALL perform one shift-add iteration and increment the counter.
 At the 32nd edge (E32), {HI,LO} SHALL load the product, two's-complemented if the negate flag is set, and the state SHALL return to IDLE.
REQ-013 o_stall SHALL be 1 when i_valid=1, ALUop in {C,D,E,F} and state==BUSY; otherwise 0. Other ops SHALL proceed while BUSY.
REQ-014 o_RegWrite SHALL equal i_RegWrite & i_valid & ~o_stall.
REQ-015 An instruction stalled at E32 SHALL proceed in the next cycle and SHALL observe the new HI/LO.
REQ-016 HI/LO SHALL change only at E32 or reset.

Reset
REQ-017 While rst=0 at an edge: state:=IDLE, counter:=0, HI:=0, LO:=0, accumulator:=0.
REQ-018 While rst=0, o_result, o_store_data, o_write_addr, o_RegWrite and o_stall SHALL be forced to 0.
REQ-019 Reset during BUSY SHALL abort the multiply; HI/LO SHALL read 0 after reset.

Verification
REQ-020 ADDU A=0xFFFFFFFF, B=1 -> o_result=0. SRA B=0x80000000, shamt=4, i_shmat=1 -> 0xF8000000.
REQ-021 SLT A=-1, B=1 -> 1. SLTU with the same operands -> 0. LUI imm=0x1234 -> 0x12340000.
REQ-022 Forwarding, i_fwd_a=01, i_exmem_result=5, i_rs_reg=9, ADDU B=1 -> 6. i_fwd_b=10 with ALUsrc=1 -> o_store_data=i_memwb_result.
REQ-023 MULT A=-3, B=7 at E0, then MFLO held valid -> o_stall=1 for 32 cycles, o_RegWrite=0 during them; next cycle o_result=0xFFFFFFEB. MFHI -> 0xFFFFFFFF.
REQ-024 MULTU A=B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001. ADDU issued while BUSY -> no stall, correct result.
REQ-025 rst=0 at E10 of a MULT -> o_mul_busy=0 next cycle. MFHI after reset -> 0.

Source files
------------

// File: rtl/ex_stage_if.sv
// EX stage bundle: ID/EX operands, control and forwarding inputs, and EX results.
// The slave side is the execute stage itself; the master side drives it.
interface ex_stage_if;
    logic        i_valid;
    logic [31:0] i_rs_reg;
    logic [31:0] i_rt_reg;
    logic [31:0] i_sig_extended;
    logic [4:0]  i_rt_addr;
    logic [4:0]  i_rd_addr;
    logic [3:0]  i_ALUop;
    logic        i_ALUsrc;
    logic        i_shmat;
    logic        i_RegDst;
    logic        i_RegWrite;
    logic [1:0]  i_fwd_a;
    logic [1:0]  i_fwd_b;
    logic [31:0] i_exmem_result;
    logic [31:0] i_memwb_result;
    logic [31:0] o_result;
    logic [31:0] o_store_data;
    logic [4:0]  o_write_addr;
    logic        o_RegWrite;
    logic        o_stall;
    logic        o_mul_busy;

    modport master (
        output i_valid, i_rs_reg, i_rt_reg, i_sig_extended, i_rt_addr, i_rd_addr,
               i_ALUop, i_ALUsrc, i_shmat, i_RegDst, i_RegWrite, i_fwd_a, i_fwd_b,
               i_exmem_result, i_memwb_result,
        input  o_result, o_store_data, o_write_addr, o_RegWrite, o_stall, o_mul_busy
    );

    modport slave (
        input  i_valid, i_rs_reg, i_rt_reg, i_sig_extended, i_rt_addr, i_rd_addr,
               i_ALUop, i_ALUsrc, i_shmat, i_RegDst, i_RegWrite, i_fwd_a, i_fwd_b,
               i_exmem_result, i_memwb_result,
        output o_result, o_store_data, o_write_addr, o_RegWrite, o_stall, o_mul_busy
    );
endinterface

// File: rtl/ex_stage.sv
// Execute stage: forwarding muxes, combinational ALU, and a 32-cycle shift-add
// multiplier feeding HI/LO. HI/LO readers stall while the multiplier iterates.
module ex_stage (
    input  logic        clk,
    input  logic        rst,
    ex_stage_if.slave   bus
);
    typedef enum logic {S_IDLE, S_BUSY} mul_state_t;

    mul_state_t  r_state, w_state_nxt;
    logic [31:0] r_hi, r_lo;
    logic [31:0] r_mcand, r_mplier;
    logic [63:0] r_acc;
    logic [4:0]  r_cnt;
    logic        r_neg;

    logic [31:0] w_op_a, w_fwd_b, w_alu_b, w_alu_res;
    logic [4:0]  w_shamt;
    logic        w_is_mul, w_is_hilo, w_stall, w_start;
    logic        w_a_neg, w_b_neg;
    logic [31:0] w_abs_a, w_abs_b;
    logic [63:0] w_pp, w_acc_nxt, w_prod;

    always_comb begin
        case (bus.i_fwd_a)
            2'b01:   w_op_a = bus.i_exmem_result;
            2'b10:   w_op_a = bus.i_memwb_result;
            default: w_op_a = bus.i_rs_reg;
        endcase
        case (bus.i_fwd_b)
            2'b01:   w_fwd_b = bus.i_exmem_result;
            2'b10:   w_fwd_b = bus.i_memwb_result;
            default: w_fwd_b = bus.i_rt_reg;
        endcase
    end

    assign w_alu_b = bus.i_ALUsrc ? bus.i_sig_extended : w_fwd_b;
    assign w_shamt = bus.i_shmat ? bus.i_sig_extended[10:6] : w_op_a[4:0];

    always_comb begin
        w_alu_res = '0;
        case (bus.i_ALUop)
            4'h0: w_alu_res = w_op_a + w_alu_b;
            4'h1: w_alu_res = w_op_a - w_alu_b;
            4'h2: w_alu_res = w_op_a & w_alu_b;
            4'h3: w_alu_res = w_op_a | w_alu_b;
            4'h4: w_alu_res = w_op_a ^ w_alu_b;
            4'h5: w_alu_res = ~(w_op_a | w_alu_b);
            4'h6: w_alu_res = {31'b0, ($signed(w_op_a) < $signed(w_alu_b))};
            4'h7: w_alu_res = {31'b0, (w_op_a < w_alu_b)};
            4'h8: w_alu_res = w_alu_b << w_shamt;
            4'h9: w_alu_res = w_alu_b >> w_shamt;
            4'hA: w_alu_res = $signed(w_alu_b) >>> w_shamt;
            4'hB: w_alu_res = {w_alu_b[15:0], 16'b0};
            4'hE: w_alu_res = r_hi;
            4'hF: w_alu_res = r_lo;
            default: w_alu_res = '0;
        endcase
    end

    // C..F all touch HI/LO; C/D start a multiply.
    assign w_is_mul  = (bus.i_ALUop[3:1] == 3'b110);
    assign w_is_hilo = (bus.i_ALUop[3:2] == 2'b11);
    assign w_stall   = bus.i_valid & w_is_hilo & (r_state == S_BUSY);
    assign w_start   = bus.i_valid & w_is_mul & ~w_stall;

    // Signed multiply runs on magnitudes; the sign is restored on the final load.
    assign w_a_neg   = ~bus.i_ALUop[0] & w_op_a[31];
    assign w_b_neg   = ~bus.i_ALUop[0] & w_alu_b[31];
    assign w_abs_a   = w_a_neg ? (32'd0 - w_op_a) : w_op_a;
    assign w_abs_b   = w_b_neg ? (32'd0 - w_alu_b) : w_alu_b;
    assign w_pp      = r_mplier[r_cnt] ? ({32'b0, r_mcand} << r_cnt) : 64'd0;
    assign w_acc_nxt = r_acc + w_pp;
    assign w_prod    = r_neg ? (64'd0 - w_acc_nxt) : w_acc_nxt;

    always_ff @(posedge clk) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_state_nxt = S_BUSY;
            S_BUSY:  if (r_cnt == 5'd31) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_neg    <= 1'b0;
        end else if (r_state == S_BUSY) begin
            r_acc <= w_acc_nxt;
            r_cnt <= r_cnt + 5'd1;
            if (r_cnt == 5'd31) {r_hi, r_lo} <= w_prod;
        end else if (w_start) begin
            r_mcand  <= w_abs_a;
            r_mplier <= w_abs_b;
            r_neg    <= w_a_neg ^ w_b_neg;
            r_acc    <= '0;
            r_cnt    <= '0;
        end
    end

    assign bus.o_result     = rst ? w_alu_res : 32'd0;
    assign bus.o_store_data = rst ? w_fwd_b : 32'd0;
    assign bus.o_write_addr = rst ? (bus.i_RegDst ? bus.i_rd_addr : bus.i_rt_addr) : 5'd0;
    assign bus.o_stall      = rst & w_stall;
    assign bus.o_RegWrite   = rst & bus.i_RegWrite & bus.i_valid & ~w_stall;
    assign bus.o_mul_busy   = (r_state == S_BUSY);
endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed vector table, randomized ALU ops
// against an arithmetic reference, and multi-cycle multiply/reset sequences.
module tb_ex_stage;
    logic clk = 1'b0;
    logic rst = 1'b0;
    ex_stage_if bus ();

    ex_stage u_dut (.clk(clk), .rst(rst), .bus(bus.slave));

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] a, b, imm;
        logic        src, sh;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] imm, input logic src, input logic sh);
        bus.i_valid = 1'b1;        bus.i_RegWrite = 1'b1;  bus.i_RegDst = 1'b1;
        bus.i_rd_addr = 5'd3;      bus.i_rt_addr = 5'd7;
        bus.i_fwd_a = 2'b00;       bus.i_fwd_b = 2'b00;
        bus.i_exmem_result = '0;   bus.i_memwb_result = '0;
        bus.i_ALUop = op;          bus.i_rs_reg = a;       bus.i_rt_reg = b;
        bus.i_sig_extended = imm;  bus.i_ALUsrc = src;     bus.i_shmat = sh;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [4:0] sh);
        logic signed [31:0] sa, sb;
        sa = a; sb = b;
        case (op)
            4'h0: return a + b;
            4'h1: return a - b;
            4'h2: return a & b;
            4'h3: return a | b;
            4'h4: return a ^ b;
            4'h5: return ~(a | b);
            4'h6: return (sa < sb) ? 32'd1 : 32'd0;
            4'h7: return (a < b) ? 32'd1 : 32'd0;
            4'h8: return b << sh;
            4'h9: return b >> sh;
            4'hA: return sb >>> sh;
            4'hB: return b * 32'd65536;
            4'hE: return m_hi;
            4'hF: return m_lo;
            default: return 32'd0;
        endcase
    endfunction

    // Issue a multiply, then either hold MFLO (mode 0) or stream ADDUs (mode 1) while busy.
    task automatic do_mul(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int mode);
        logic [63:0] p;
        int cyc;
        logic [31:0] x, y;
        if (op == 4'hC) p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        else            p = {32'b0, a} * {32'b0, b};
        drive(op, a, b, 32'd0, 1'b0, 1'b0);
        #1;
        chk("mul_issue_stall", {31'b0, bus.o_stall}, 32'd0);
        chk("mul_issue_result", bus.o_result, 32'd0);
        @(posedge clk); #1;
        cyc = 0;
        while (bus.o_mul_busy && cyc < 40) begin
            if (mode == 0) begin
                drive(4'hF, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
                #1;
                chk("busy_mflo_stall", {31'b0, bus.o_stall}, 32'd1);
                chk("busy_mflo_regwrite", {31'b0, bus.o_RegWrite}, 32'd0);
            end else begin
                x = $urandom; y = $urandom;
                drive(4'h0, x, y, 32'd0, 1'b0, 1'b0);
                #1;
                chk("busy_addu_stall", {31'b0, bus.o_stall}, 32'd0);
                chk("busy_addu_result", bus.o_result, x + y);
            end
            @(posedge clk); #1;
            cyc++;
        end
        chk("mul_cycles", cyc, 32'd32);
        m_hi = p[63:32]; m_lo = p[31:0];
        drive(4'hF, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        #1;
        chk("mflo_after_stall", {31'b0, bus.o_stall}, 32'd0);
        chk("mflo_after_regwrite", {31'b0, bus.o_RegWrite}, 32'd1);
        chk("mflo_value", bus.o_result, m_lo);
        tick();
        drive(4'hE, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        #1;
        chk("mfhi_value", bus.o_result, m_hi);
        tick();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        logic [3:0]  op;
        logic [31:0] a, b, imm, ex, mw, opa, fb, alub;
        logic [1:0]  fa, fbs;
        logic        src, sh, vld, rw, rd;

        vecs[0]  = '{"addu_wrap", 4'h0, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 1'b0, 32'd0};
        vecs[1]  = '{"subu_wrap", 4'h1, 32'd0, 32'd1, 32'd0, 1'b0, 1'b0, 32'hFFFFFFFF};
        vecs[2]  = '{"and", 4'h2, 32'hF0F0F0F0, 32'hFF00FF00, 32'd0, 1'b0, 1'b0, 32'hF000F000};
        vecs[3]  = '{"or",  4'h3, 32'hF0F0F0F0, 32'hFF00FF00, 32'd0, 1'b0, 1'b0, 32'hFFF0FFF0};
        vecs[4]  = '{"xor", 4'h4, 32'hF0F0F0F0, 32'hFF00FF00, 32'd0, 1'b0, 1'b0, 32'h0FF00FF0};
        vecs[5]  = '{"nor", 4'h5, 32'hF0F0F0F0, 32'hFF00FF00, 32'd0, 1'b0, 1'b0, 32'h000F000F};
        vecs[6]  = '{"slt",  4'h6, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 1'b0, 32'd1};
        vecs[7]  = '{"sltu", 4'h7, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 1'b0, 32'd0};
        vecs[8]  = '{"sll_var", 4'h8, 32'd31, 32'd1, 32'd0, 1'b0, 1'b0, 32'h80000000};
        vecs[9]  = '{"srl_var", 4'h9, 32'd4, 32'h80000000, 32'd0, 1'b0, 1'b0, 32'h08000000};
        vecs[10] = '{"sra_shamt", 4'hA, 32'd0, 32'h80000000, 32'h00000100, 1'b0, 1'b1, 32'hF8000000};
        vecs[11] = '{"lui", 4'hB, 32'd0, 32'd0, 32'h00001234, 1'b1, 1'b0, 32'h12340000};

        // Reset: outputs forced low even with a valid MFLO presented.
        drive(4'hF, 32'h11, 32'h22, 32'd0, 1'b0, 1'b0);
        #1;
        chk("rst_result", bus.o_result, 32'd0);
        chk("rst_store", bus.o_store_data, 32'd0);
        chk("rst_waddr", {27'b0, bus.o_write_addr}, 32'd0);
        chk("rst_regwrite", {31'b0, bus.o_RegWrite}, 32'd0);
        tick(); tick();
        chk("rst_busy", {31'b0, bus.o_mul_busy}, 32'd0);
        rst = 1'b1;
        #1;
        chk("rst_lo_zero", bus.o_result, 32'd0);
        tick();

        foreach (vecs[i]) begin
            drive(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].imm, vecs[i].src, vecs[i].sh);
            #1;
            chk(vecs[i].name, bus.o_result, vecs[i].exp);
            tick();
        end

        drive(4'h0, 32'd9, 32'd0, 32'd1, 1'b1, 1'b0);
        bus.i_fwd_a = 2'b01; bus.i_exmem_result = 32'd5;
        #1;
        chk("fwd_a_exmem", bus.o_result, 32'd6);
        tick();
        drive(4'h0, 32'd0, 32'h1111, 32'd4, 1'b1, 1'b0);
        bus.i_fwd_b = 2'b10; bus.i_memwb_result = 32'hCAFEF00D;
        #1;
        chk("fwd_b_store", bus.o_store_data, 32'hCAFEF00D);
        chk("fwd_b_alusrc", bus.o_result, 32'd4);
        tick();

        for (int i = 0; i < 300; i++) begin
            op = 4'($urandom_range(0, 11));
            a = $urandom; b = $urandom; imm = $urandom; ex = $urandom; mw = $urandom;
            fa = 2'($urandom); fbs = 2'($urandom);
            src = 1'($urandom); sh = 1'($urandom); vld = 1'($urandom);
            rw = 1'($urandom); rd = 1'($urandom);
            drive(op, a, b, imm, src, sh);
            bus.i_fwd_a = fa; bus.i_fwd_b = fbs;
            bus.i_exmem_result = ex; bus.i_memwb_result = mw;
            bus.i_valid = vld; bus.i_RegWrite = rw; bus.i_RegDst = rd;
            opa  = (fa == 2'b01) ? ex : (fa == 2'b10) ? mw : a;
            fb   = (fbs == 2'b01) ? ex : (fbs == 2'b10) ? mw : b;
            alub = src ? imm : fb;
            #1;
            chk("rand_result", bus.o_result, ref_alu(op, opa, alub, sh ? imm[10:6] : opa[4:0]));
            chk("rand_store", bus.o_store_data, fb);
            chk("rand_waddr", {27'b0, bus.o_write_addr}, {27'b0, rd ? 5'd3 : 5'd7});
            chk("rand_regwrite", {31'b0, bus.o_RegWrite}, {31'b0, rw & vld});
            tick();
        end

        do_mul(4'hC, 32'hFFFFFFFD, 32'd7, 0);
        do_mul(4'hD, 32'hFFFFFFFF, 32'hFFFFFFFF, 1);
        for (int i = 0; i < 4; i++)
            do_mul(4'($urandom_range(12, 13)), $urandom, $urandom, i % 2);
        do_mul(4'hC, 32'h80000000, 32'hFFFFFFFF, 0);

        // Reset lands on the tenth busy edge and aborts the multiply.
        drive(4'hC, 32'd123, 32'd456, 32'd0, 1'b0, 1'b0);
        tick();
        drive(4'hF, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) tick();
        chk("abort_busy_before", {31'b0, bus.o_mul_busy}, 32'd1);
        rst = 1'b0;
        #1;
        chk("abort_rst_stall", {31'b0, bus.o_stall}, 32'd0);
        chk("abort_rst_result", bus.o_result, 32'd0);
        tick();
        chk("abort_busy_after", {31'b0, bus.o_mul_busy}, 32'd0);
        rst = 1'b1;
        m_hi = '0; m_lo = '0;
        drive(4'hE, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        #1;
        chk("abort_mfhi", bus.o_result, 32'd0);
        chk("abort_mfhi_stall", {31'b0, bus.o_stall}, 32'd0);
        tick();
        drive(4'hF, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        #1;
        chk("abort_mflo", bus.o_result, 32'd0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
